// File: rtl/regfile_dump.sv
// Parametrised ID-stage register file with two combinational read ports, one write port
// and a handshaked dump engine. Define REGFILE_WRITE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_dump #(
    parameter int NBITS    = 32,
    parameter int REGS     = 5,
    parameter int CELDAS   = 32,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_RegWrite,
    input  logic [REGS-1:0]  i_RS,
    input  logic [REGS-1:0]  i_RT,
    input  logic [REGS-1:0]  i_RD,
    input  logic [NBITS-1:0] i_DatoEscritura,
    output logic [NBITS-1:0] o_RS,
    output logic [NBITS-1:0] o_RT,
    input  logic             i_DumpStart,
    input  logic             i_DumpReady,
    output logic             o_DumpValid,
    output logic [REGS-1:0]  o_DumpAddr,
    output logic [NBITS-1:0] o_DumpData,
    output logic             o_DumpBusy,
    output logic             o_DumpDone
);

    localparam logic [31:0]     NCELLS    = 32'(CELDAS);
    localparam logic [REGS-1:0] LAST_ADDR = REGS'(CELDAS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } dump_state_t;

    logic [NBITS-1:0] mem [CELDAS];
    dump_state_t      state;
    logic             write_ok;
    logic [REGS-1:0]  next_addr;
    logic [NBITS-1:0] next_word;
    logic [NBITS-1:0] first_word;

    function automatic logic in_range(input logic [REGS-1:0] a);
        return 32'(a) < NCELLS;
    endfunction

    function automatic logic is_zero_reg(input logic [REGS-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic [NBITS-1:0] lookup(input logic [REGS-1:0] a);
        logic [NBITS-1:0] v;
        v = '0;
        for (int i = 0; i < CELDAS; i++) begin
            if (a == REGS'(i)) begin
                v = mem[i];
            end
        end
        return v;
    endfunction

    // Shared by both read ports and the dump loader so all three see identical data.
    function automatic logic [NBITS-1:0] read_reg(input logic [REGS-1:0] a);
        logic [NBITS-1:0] v;
        v = '0;
        if (in_range(a) && !is_zero_reg(a)) begin
`ifdef REGFILE_WRITE_BYPASS_EN
            if (write_ok && (a == i_RD)) begin
                v = i_DatoEscritura;
            end else begin
                v = lookup(a);
            end
`else
            v = lookup(a);
`endif
        end
        return v;
    endfunction

    assign write_ok  = i_RegWrite && in_range(i_RD) && !is_zero_reg(i_RD);
    assign next_addr = o_DumpAddr + REGS'(1);

    always_comb begin
        o_RS       = read_reg(i_RS);
        o_RT       = read_reg(i_RT);
        next_word  = read_reg(next_addr);
        first_word = read_reg('0);
    end

    // Reset preloads each register with its own index, which makes dumps easy to eyeball.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CELDAS; i++) begin
                mem[i] <= NBITS'(i);
            end
        end else begin
            for (int i = 0; i < CELDAS; i++) begin
                if (write_ok && (i_RD == REGS'(i))) begin
                    mem[i] <= i_DatoEscritura;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            o_DumpValid <= 1'b0;
            o_DumpBusy  <= 1'b0;
            o_DumpDone  <= 1'b0;
            o_DumpAddr  <= '0;
            o_DumpData  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    o_DumpDone <= 1'b0;
                    if (i_DumpStart) begin
                        state       <= SEND;
                        o_DumpValid <= 1'b1;
                        o_DumpBusy  <= 1'b1;
                        o_DumpAddr  <= '0;
                        o_DumpData  <= first_word;
                    end
                end
                SEND: begin
                    if (o_DumpValid && i_DumpReady) begin
                        if (o_DumpAddr == LAST_ADDR) begin
                            state       <= DONE;
                            o_DumpValid <= 1'b0;
                            o_DumpBusy  <= 1'b0;
                        end else begin
                            o_DumpAddr <= next_addr;
                            o_DumpData <= next_word;
                        end
                    end
                end
                DONE: begin
                    o_DumpDone <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    o_DumpValid <= 1'b0;
                    o_DumpBusy  <= 1'b0;
                    o_DumpDone  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: reset values, read/write paths, zero register,
// out-of-range addresses and the dump handshake including mid-dump reset.
module tb_regfile_dump;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        dump_start;
    logic        dump_ready;
    logic [31:0] out_rs;
    logic [31:0] out_rt;
    logic        dump_valid;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        dump_done;

    logic        z_start;
    logic [31:0] z_rs;
    logic [31:0] z_rt;
    logic        z_valid;
    logic [4:0]  z_addr;
    logic [31:0] z_data;
    logic        z_busy;
    logic        z_done;

    int errors;
    int checks;

    logic [31:0] exp_mem [32];
    logic [4:0]  exp_addr;
    logic        finished;
    logic        wrote;
    logic [31:0] exp_word;

    regfile_dump dut (
        .clk             (clk),
        .reset           (reset),
        .i_RegWrite      (reg_write),
        .i_RS            (rs),
        .i_RT            (rt),
        .i_RD            (rd),
        .i_DatoEscritura (wdata),
        .o_RS            (out_rs),
        .o_RT            (out_rt),
        .i_DumpStart     (dump_start),
        .i_DumpReady     (dump_ready),
        .o_DumpValid     (dump_valid),
        .o_DumpAddr      (dump_addr),
        .o_DumpData      (dump_data),
        .o_DumpBusy      (dump_busy),
        .o_DumpDone      (dump_done)
    );

    // Small instance without a hardwired zero and with fewer cells than the address space.
    regfile_dump #(.NBITS(32), .REGS(5), .CELDAS(24), .ZERO_REG(0)) z0 (
        .clk             (clk),
        .reset           (reset),
        .i_RegWrite      (reg_write),
        .i_RS            (rs),
        .i_RT            (rt),
        .i_RD            (rd),
        .i_DatoEscritura (wdata),
        .o_RS            (z_rs),
        .o_RT            (z_rt),
        .i_DumpStart     (z_start),
        .i_DumpReady     (dump_ready),
        .o_DumpValid     (z_valid),
        .o_DumpAddr      (z_addr),
        .o_DumpData      (z_data),
        .o_DumpBusy      (z_busy),
        .o_DumpDone      (z_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] a_rs, input logic [4:0] a_rt,
                                 input logic [4:0] a_rd, input logic [31:0] d);
        reg_write = we;
        rs        = a_rs;
        rt        = a_rt;
        rd        = a_rd;
        wdata     = d;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        z_start    = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);

        checkOutput("rst_valid", 32'(dump_valid), 32'd0);
        checkOutput("rst_busy",  32'(dump_busy),  32'd0);

        reset = 1'b1;
        applyStimulus(1'b0, 5'd7, 5'd31, 5'd0, 32'h0);
        #1;
        checkOutput("rst_rs7",   out_rs, 32'd7);
        checkOutput("rst_rt31",  out_rt, 32'd31);
        checkOutput("rst_done",  32'(dump_done), 32'd0);
        checkOutput("rst_addr",  32'(dump_addr), 32'd0);
        checkOutput("rst_data",  dump_data, 32'd0);

        // Write then read back, same cycle and next cycle
        @(negedge clk);
        applyStimulus(1'b1, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF);
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        checkOutput("wr_same_cycle", out_rs, 32'hDEADBEEF);
`else
        checkOutput("wr_same_cycle", out_rs, 32'd5);
`endif
        checkOutput("rt_zero_reg", out_rt, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 5'd5, 5'd0, 5'd0, 32'h0);
        #1;
        checkOutput("wr_next_cycle", out_rs, 32'hDEADBEEF);

        // Register zero: discarded on the main instance, stored on z0
        @(negedge clk);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 32'h1234);
        #1;
        checkOutput("zero_same_main", out_rs, 32'd0);
`ifdef REGFILE_WRITE_BYPASS_EN
        checkOutput("zero_same_z0", z_rs, 32'h1234);
`else
        checkOutput("zero_same_z0", z_rs, 32'd0);
`endif
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 5'd23, 5'd0, 32'h0);
        #1;
        checkOutput("zero_main", out_rs, 32'd0);
        checkOutput("zero_z0",   z_rs,   32'h1234);
        checkOutput("z0_last",   z_rt,   32'd23);

        // Addresses beyond CELDAS on z0
        @(negedge clk);
        applyStimulus(1'b1, 5'd30, 5'd24, 5'd30, 32'h5555);
        #1;
        checkOutput("oor_main_rt", out_rt, 32'd24);
        checkOutput("oor_z0_rt",   z_rt,   32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 5'd30, 5'd0, 5'd0, 32'h0);
        #1;
        checkOutput("oor_main_wr", out_rs, 32'h5555);
        checkOutput("oor_z0_wr",   z_rs,   32'd0);

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_restore", out_rs, 32'd30);
        checkOutput("rst_restore_rs5", z_rs, 32'd30 == 32'd30 ? 32'd0 : 32'd0);

        // Full dump with ready held high
        @(negedge clk);
        dump_start = 1'b1;
        dump_ready = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("d1_valid%0d", k), 32'(dump_valid), 32'd1);
            checkOutput($sformatf("d1_addr%0d", k),  32'(dump_addr),  32'(k));
            checkOutput($sformatf("d1_data%0d", k),  dump_data,       32'(k));
            checkOutput($sformatf("d1_done%0d", k),  32'(dump_done),  32'd0);
        end
        @(negedge clk);
        checkOutput("d1_end_valid", 32'(dump_valid), 32'd0);
        checkOutput("d1_end_busy",  32'(dump_busy),  32'd0);
        checkOutput("d1_end_done",  32'(dump_done),  32'd0);
        checkOutput("d1_end_addr",  32'(dump_addr),  32'd31);
        @(negedge clk);
        checkOutput("d1_done_pulse", 32'(dump_done), 32'd1);
        checkOutput("d1_done_addr",  32'(dump_addr), 32'd31);
        @(negedge clk);
        checkOutput("d1_done_clear", 32'(dump_done), 32'd0);
        checkOutput("d1_idle_valid", 32'(dump_valid), 32'd0);

        // Dump with ready toggling and a write landing mid-dump
        for (int k = 0; k < 32; k++) exp_mem[k] = 32'(k);
        exp_addr = 5'd0;
        finished = 1'b0;
        wrote    = 1'b0;
        @(negedge clk);
        dump_start = 1'b1;
        dump_ready = 1'b0;
        @(negedge clk);
        dump_start = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            reg_write = 1'b0;
            exp_word  = exp_mem[exp_addr];
            checkOutput($sformatf("d2_valid_c%0d", cyc), 32'(dump_valid), 32'd1);
            checkOutput($sformatf("d2_addr_c%0d", cyc),  32'(dump_addr),  32'(exp_addr));
            checkOutput($sformatf("d2_data_c%0d", cyc),  dump_data,       exp_word);
            dump_ready = (cyc % 2 == 0);
            if (exp_addr == 5'd3 && !wrote) begin
                applyStimulus(1'b1, 5'd0, 5'd0, 5'd20, 32'hAA);
                exp_mem[20] = 32'hAA;
                wrote = 1'b1;
            end
            if (dump_ready) begin
                if (exp_addr == 5'd31) finished = 1'b1;
                else exp_addr = exp_addr + 5'd1;
            end
        end
        checkOutput("d2_finished", 32'(finished), 32'd1);
        @(negedge clk);
        reg_write  = 1'b0;
        checkOutput("d2_end_valid", 32'(dump_valid), 32'd0);
        checkOutput("d2_end_done",  32'(dump_done),  32'd0);
        @(negedge clk);
        checkOutput("d2_done_pulse", 32'(dump_done), 32'd1);

        // Reset in the middle of a dump
        @(negedge clk);
        applyStimulus(1'b0, 5'd20, 5'd0, 5'd0, 32'h0);
        dump_start = 1'b1;
        dump_ready = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("d3_addr10",   32'(dump_addr), 32'd10);
        checkOutput("d3_reg20_aa", out_rs, 32'hAA);
        reset = 1'b0;
        #1;
        checkOutput("d3_rst_valid", 32'(dump_valid), 32'd0);
        checkOutput("d3_rst_busy",  32'(dump_busy),  32'd0);
        checkOutput("d3_rst_addr",  32'(dump_addr),  32'd0);
        checkOutput("d3_rst_data",  dump_data,       32'd0);
        checkOutput("d3_rst_reg20", out_rs,          32'd20);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("d3_no_done%0d", k),  32'(dump_done),  32'd0);
            checkOutput($sformatf("d3_no_valid%0d", k), 32'(dump_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
